// File: rtl/battle_board_engine.sv
// Two-player Battleship game-state engine: board storage, shot resolution,
// turn/score tracking and a combinational row-read port for the display.
module battle_board_engine #(
   parameter int BOARD_SIZE = 10,
   parameter int COORD_W    = 4,
   parameter int SHIP_CELLS = 17,
   parameter int HIT_W      = 5
) (
   input  logic                    clock50,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic                    load_player,
   input  logic [COORD_W-1:0]      load_row,
   input  logic [2*BOARD_SIZE-1:0] load_data,
   input  logic                    start,
   input  logic                    new_game,
   input  logic                    fire_valid,
   input  logic [COORD_W-1:0]      fire_row,
   input  logic [COORD_W-1:0]      fire_col,
   output logic                    fire_ready,
   output logic                    result_valid,
   output logic [1:0]              result_code,
   output logic                    player_turn,
   output logic [HIT_W-1:0]        hits_p0,
   output logic [HIT_W-1:0]        hits_p1,
   output logic                    game_over,
   output logic                    winner,
   input  logic                    read_player,
   input  logic [COORD_W-1:0]      read_row,
   output logic [2*BOARD_SIZE-1:0] read_data
);

   localparam int ROW_W = 2 * BOARD_SIZE;
   localparam logic [COORD_W-1:0] COORD_LIMIT = COORD_W'(BOARD_SIZE);
   localparam logic [HIT_W-1:0]   WIN_HITS    = HIT_W'(SHIP_CELLS);
   localparam logic [HIT_W-1:0]   HIT_ONE     = HIT_W'(1);

   localparam logic [1:0] CELL_WATER = 2'b00;
   localparam logic [1:0] CELL_SHIP  = 2'b01;
   localparam logic [1:0] CELL_MISS  = 2'b10;
   localparam logic [1:0] CELL_HIT   = 2'b11;

   localparam logic [1:0] CODE_REJECT = 2'b00;
   localparam logic [1:0] CODE_MISS   = 2'b01;
   localparam logic [1:0] CODE_HIT    = 2'b10;
   localparam logic [1:0] CODE_WIN    = 2'b11;

   typedef enum logic [2:0] {
      ST_SETUP    = 3'd0,
      ST_PLAY     = 3'd1,
      ST_RESOLVE  = 3'd2,
      ST_REPORT   = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_t;

   state_t             state_r;
   state_t             next_state_s;

   logic [ROW_W-1:0]   board_r [2][BOARD_SIZE];

   logic               shooter_r;
   logic [COORD_W-1:0] row_r;
   logic [COORD_W-1:0] col_r;
   logic [1:0]         pend_code_r;
   logic               result_valid_r;
   logic [1:0]         result_code_r;
   logic               turn_r;
   logic               winner_r;
   logic [HIT_W-1:0]   hits_p0_r;
   logic [HIT_W-1:0]   hits_p1_r;

   logic [ROW_W-1:0]   tgt_row_s;
   logic [1:0]         tgt_cell_s;
   logic               in_range_s;
   logic [HIT_W-1:0]   cur_hits_s;
   logic [HIT_W-1:0]   next_hits_s;
   logic [1:0]         res_code_s;
   logic               write_en_s;
   logic [1:0]         write_val_s;
   logic               hit_s;
   logic [ROW_W-1:0]   read_data_s;

   // State register
   always_ff @(posedge clock50) begin
      if (reset) begin
         state_r <= ST_SETUP;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_SETUP:    next_state_s = start      ? ST_PLAY    : ST_SETUP;
         ST_PLAY:     next_state_s = fire_valid ? ST_RESOLVE : ST_PLAY;
         ST_RESOLVE:  next_state_s = ST_REPORT;
         ST_REPORT:   next_state_s = (pend_code_r == CODE_WIN) ? ST_GAMEOVER : ST_PLAY;
         ST_GAMEOVER: next_state_s = new_game   ? ST_SETUP   : ST_GAMEOVER;
         default:     next_state_s = ST_SETUP;
      endcase
   end

   // Fetch the latched target cell from the opponent's board
   always_comb begin
      tgt_row_s = {ROW_W{1'b0}};
      for (int r = 0; r < BOARD_SIZE; r++) begin
         tgt_row_s = (row_r == COORD_W'(r)) ? board_r[~shooter_r][r] : tgt_row_s;
      end
      tgt_cell_s = CELL_WATER;
      for (int c = 0; c < BOARD_SIZE; c++) begin
         tgt_cell_s = (col_r == COORD_W'(c)) ? tgt_row_s[2*c +: 2] : tgt_cell_s;
      end
      in_range_s = (row_r < COORD_LIMIT) && (col_r < COORD_LIMIT);
   end

   // Shot outcome; the hit counter saturates so a stray extra ship cell cannot wrap it
   always_comb begin
      cur_hits_s  = shooter_r ? hits_p1_r : hits_p0_r;
      next_hits_s = (cur_hits_s < WIN_HITS) ? (cur_hits_s + HIT_ONE) : cur_hits_s;
      res_code_s  = CODE_REJECT;
      write_en_s  = 1'b0;
      write_val_s = CELL_MISS;
      hit_s       = 1'b0;
      if (in_range_s) begin
         case (tgt_cell_s)
            CELL_WATER: begin
               write_en_s  = 1'b1;
               write_val_s = CELL_MISS;
               res_code_s  = CODE_MISS;
            end
            CELL_SHIP: begin
               write_en_s  = 1'b1;
               write_val_s = CELL_HIT;
               hit_s       = 1'b1;
               res_code_s  = (next_hits_s == WIN_HITS) ? CODE_WIN : CODE_HIT;
            end
            default: begin
               res_code_s  = CODE_REJECT;
            end
         endcase
      end else begin
         res_code_s = CODE_REJECT;
      end
   end

   // Board storage: clear, setup-time row loads, and the resolve write-back
   always_ff @(posedge clock50) begin
      if (reset || ((state_r == ST_GAMEOVER) && new_game)) begin
         for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < BOARD_SIZE; r++) begin
               board_r[p][r] <= {ROW_W{1'b0}};
            end
         end
      end else if ((state_r == ST_SETUP) && load_en) begin
         for (int r = 0; r < BOARD_SIZE; r++) begin
            if (load_row == COORD_W'(r)) begin
               board_r[load_player][r] <= load_data;
            end
         end
      end else if ((state_r == ST_RESOLVE) && write_en_s) begin
         for (int r = 0; r < BOARD_SIZE; r++) begin
            for (int c = 0; c < BOARD_SIZE; c++) begin
               if ((row_r == COORD_W'(r)) && (col_r == COORD_W'(c))) begin
                  board_r[~shooter_r][r][2*c +: 2] <= write_val_s;
               end
            end
         end
      end
   end

   // Shot latch, scoring, turn, winner and the result pulse
   always_ff @(posedge clock50) begin
      if (reset) begin
         shooter_r      <= 1'b0;
         row_r          <= {COORD_W{1'b0}};
         col_r          <= {COORD_W{1'b0}};
         pend_code_r    <= CODE_REJECT;
         result_valid_r <= 1'b0;
         result_code_r  <= CODE_REJECT;
         turn_r         <= 1'b0;
         winner_r       <= 1'b0;
         hits_p0_r      <= {HIT_W{1'b0}};
         hits_p1_r      <= {HIT_W{1'b0}};
      end else begin
         result_valid_r <= 1'b0;
         case (state_r)
            ST_SETUP: begin
               if (start) begin
                  turn_r <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (fire_valid) begin
                  shooter_r <= turn_r;
                  row_r     <= fire_row;
                  col_r     <= fire_col;
               end
            end
            ST_RESOLVE: begin
               pend_code_r <= res_code_s;
               if (hit_s) begin
                  if (shooter_r) begin
                     hits_p1_r <= next_hits_s;
                  end else begin
                     hits_p0_r <= next_hits_s;
                  end
               end
            end
            ST_REPORT: begin
               result_valid_r <= 1'b1;
               result_code_r  <= pend_code_r;
               if (pend_code_r == CODE_WIN) begin
                  winner_r <= shooter_r;
               end else if (pend_code_r != CODE_REJECT) begin
                  turn_r <= ~shooter_r;
               end
            end
            ST_GAMEOVER: begin
               if (new_game) begin
                  hits_p0_r <= {HIT_W{1'b0}};
                  hits_p1_r <= {HIT_W{1'b0}};
                  turn_r    <= 1'b0;
                  winner_r  <= 1'b0;
               end
            end
            default: begin
               result_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Display read port; rows beyond the board match nothing and read as zero
   always_comb begin
      read_data_s = {ROW_W{1'b0}};
      for (int r = 0; r < BOARD_SIZE; r++) begin
         read_data_s = (read_row == COORD_W'(r)) ? board_r[read_player][r] : read_data_s;
      end
   end

   assign read_data    = read_data_s;
   assign fire_ready   = (state_r == ST_PLAY);
   assign game_over    = (state_r == ST_GAMEOVER);
   assign result_valid = result_valid_r;
   assign result_code  = result_code_r;
   assign player_turn  = turn_r;
   assign winner       = winner_r;
   assign hits_p0      = hits_p0_r;
   assign hits_p1      = hits_p1_r;

endmodule

// File: tb/tb_battle_board_engine.sv
// Self-checking bench for battle_board_engine: a cell-level game model drives
// per-cycle status checks, pinned by hand-computed literal expectations.
module tb_battle_board_engine;

   localparam int BS = 10;
   localparam int CW = 4;
   localparam int SC = 2;
   localparam int HW = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            load_en = 1'b0;
   logic            load_player = 1'b0;
   logic [CW-1:0]   load_row = '0;
   logic [2*BS-1:0] load_data = '0;
   logic            start = 1'b0;
   logic            new_game = 1'b0;
   logic            fire_valid = 1'b0;
   logic [CW-1:0]   fire_row = '0;
   logic [CW-1:0]   fire_col = '0;
   logic            fire_ready;
   logic            result_valid;
   logic [1:0]      result_code;
   logic            player_turn;
   logic [HW-1:0]   hits_p0;
   logic [HW-1:0]   hits_p1;
   logic            game_over;
   logic            winner;
   logic            read_player = 1'b0;
   logic [CW-1:0]   read_row = '0;
   logic [2*BS-1:0] read_data;

   battle_board_engine #(.BOARD_SIZE(BS), .COORD_W(CW), .SHIP_CELLS(SC), .HIT_W(HW)) dut (
      .clock50(clk), .reset(reset), .load_en(load_en), .load_player(load_player),
      .load_row(load_row), .load_data(load_data), .start(start), .new_game(new_game),
      .fire_valid(fire_valid), .fire_row(fire_row), .fire_col(fire_col),
      .fire_ready(fire_ready), .result_valid(result_valid), .result_code(result_code),
      .player_turn(player_turn), .hits_p0(hits_p0), .hits_p1(hits_p1),
      .game_over(game_over), .winner(winner), .read_player(read_player),
      .read_row(read_row), .read_data(read_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Game model: cell grid, scores and expected status outputs
   logic [1:0] mb [2][BS][BS];
   int         mh [2];
   bit         e_ready, e_over, e_turn, e_winner, e_rv;
   logic [1:0] e_code;
   bit         chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*BS-1:0] model_row(input int p, input int r);
      logic [2*BS-1:0] v;
      v = '0;
      if (r < BS) begin
         for (int c = 0; c < BS; c++) v[2*c +: 2] = mb[p][r][c];
      end
      return v;
   endfunction

   task automatic model_clear();
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < BS; r++)
            for (int c = 0; c < BS; c++) mb[p][r][c] = 2'b00;
      mh[0] = 0; mh[1] = 0;
      e_turn = 1'b0; e_winner = 1'b0; e_over = 1'b0; e_ready = 1'b0; e_rv = 1'b0;
   endtask

   // Per-cycle status compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("fire_ready", fire_ready, e_ready);
         chk("game_over", game_over, e_over);
         chk("player_turn", player_turn, e_turn);
         chk("hits_p0", hits_p0, mh[0]);
         chk("hits_p1", hits_p1, mh[1]);
         chk("result_valid", result_valid, e_rv);
         chk("result_code", result_code, e_code);
         if (e_over) chk("winner", winner, e_winner);
      end
   end

   task automatic check_boards();
      for (int p = 0; p < 2; p++) begin
         for (int r = 0; r < 16; r++) begin
            read_player = p[0];
            read_row    = CW'(r);
            #1;
            chk("read_data", read_data, model_row(p, r));
         end
      end
   endtask

   task automatic load(input bit p, input int r, input logic [2*BS-1:0] d, input bit st);
      load_en = 1'b1; load_player = p; load_row = CW'(r); load_data = d; start = st;
      @(posedge clk); #1;
      if (r < BS) begin
         for (int c = 0; c < BS; c++) mb[p][r][c] = d[2*c +: 2];
      end
      if (st) begin e_ready = 1'b1; e_turn = 1'b0; end
      load_en = 1'b0; start = 1'b0;
   endtask

   task automatic fire(input int r, input int c, input bit stray, input logic [1:0] want);
      bit shooter, tgt, wr;
      logic [1:0] code, nv;
      int nh;
      shooter = e_turn; tgt = ~shooter; wr = 1'b0; code = 2'b00; nv = 2'b00; nh = mh[shooter];
      if (r < BS && c < BS) begin
         if (mb[tgt][r][c] == 2'b00) begin
            wr = 1'b1; nv = 2'b10; code = 2'b01;
         end else if (mb[tgt][r][c] == 2'b01) begin
            wr = 1'b1; nv = 2'b11;
            nh = (mh[shooter] < SC) ? mh[shooter] + 1 : mh[shooter];
            code = (nh == SC) ? 2'b11 : 2'b10;
         end
      end
      fire_valid = 1'b1; fire_row = CW'(r); fire_col = CW'(c);
      @(posedge clk); #1;
      fire_valid = stray; e_ready = 1'b0;
      @(posedge clk); #1;
      if (wr) mb[tgt][r][c] = nv;
      mh[shooter] = nh;
      read_player = tgt; read_row = CW'(r); #1;
      chk("row_after_write", read_data, model_row(tgt, r));
      @(posedge clk); #1;
      fire_valid = 1'b0;
      e_rv = 1'b1; e_code = code;
      if (code == 2'b11) begin
         e_over = 1'b1; e_winner = shooter;
      end else begin
         e_ready = 1'b1;
         if (code != 2'b00) e_turn = ~shooter;
      end
      chk("code_literal", result_code, want);
      @(posedge clk); #1;
      e_rv = 1'b0;
   endtask

   initial begin
      model_clear();
      e_code = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_boards();

      // Setup: ships on player two (2,3) and (5,7), player one (4,1); bad row ignored
      load(1'b1, 2, 20'h00040, 1'b0);
      load(1'b1, 12, 20'h55555, 1'b0);
      load(1'b1, 5, 20'h04000, 1'b0);
      load(1'b0, 4, 20'h00004, 1'b1);
      check_boards();

      fire(2, 3, 1'b0, 2'b10);
      chk("hits_p0_lit", hits_p0, 1);
      chk("turn_lit_1", player_turn, 1'b1);
      read_player = 1'b1; read_row = 4'd2; #1;
      chk("p2_row2_lit", read_data, 20'h000C0);

      fire(0, 0, 1'b0, 2'b01);
      chk("turn_lit_0", player_turn, 1'b0);
      read_player = 1'b0; read_row = 4'd0; #1;
      chk("p1_row0_lit", read_data, 20'h00002);

      fire(9, 9, 1'b0, 2'b01);
      fire(0, 0, 1'b0, 2'b00);
      chk("repeat_turn_lit", player_turn, 1'b1);
      chk("hits_p1_lit0", hits_p1, 0);
      fire(10, 4, 1'b1, 2'b00);
      fire(3, 15, 1'b0, 2'b00);
      chk("oob_turn_lit", player_turn, 1'b1);

      // Loads and start are ignored once play has begun
      load_en = 1'b1; load_player = 1'b0; load_row = 4'd0; load_data = 20'hFFFFF; start = 1'b1;
      @(posedge clk); #1;
      load_en = 1'b0; start = 1'b0;
      check_boards();

      fire(4, 1, 1'b0, 2'b10);
      chk("hits_p1_lit1", hits_p1, 1);
      fire(5, 7, 1'b0, 2'b11);
      chk("over_lit", game_over, 1'b1);
      chk("winner_lit", winner, 1'b0);
      chk("hits_p0_lit2", hits_p0, 2);

      fire_valid = 1'b1; fire_row = 4'd1; fire_col = 4'd1;
      repeat (4) @(posedge clk);
      #1;
      fire_valid = 1'b0;
      chk("gameover_no_result", result_valid, 1'b0);
      check_boards();

      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      model_clear();
      check_boards();
      chk("new_game_hits_lit", hits_p0, 0);

      // Reset during the resolve cycle of a hit
      load(1'b1, 0, 20'h00001, 1'b1);
      fire_valid = 1'b1; fire_row = 4'd0; fire_col = 4'd0;
      @(posedge clk); #1;
      fire_valid = 1'b0; e_ready = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      e_code = 2'b00;
      repeat (4) @(posedge clk);
      #1;
      read_player = 1'b1; read_row = 4'd0; #1;
      chk("reset_resolve_cell_lit", read_data, 20'h00000);
      chk("reset_resolve_ready_lit", fire_ready, 1'b0);
      chk("reset_resolve_hits_lit", hits_p0, 0);
      check_boards();

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
